// File: rtl/branch_redirect_ctrl.sv
// Taken-branch redirect sequencer: evaluates BEQ (branch & zero) from EX/MEM, drives
// the PC-source select and target, holds the pipeline flush for the squash window.
module branch_redirect_ctrl #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch,
  input  logic             zero,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             stall,
  input  logic             clear_stats,
  output logic             pc_src,
  output logic [PC_W-1:0]  pc_target,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int unsigned SQ_W = 4;
  localparam logic [SQ_W-1:0] SQ_INIT = SQ_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
  logic              pc_src_q, pc_src_d;
  logic              flush_q, flush_d;
  logic              busy_q, busy_d;
  logic [PC_W-1:0]   pc_target_q, pc_target_d;
  logic [CNT_W-1:0]  branch_count_q, branch_count_d;
  logic [CNT_W-1:0]  taken_count_q, taken_count_d;

  logic              sample_c;
  logic              taken_c;

  // Branch/zero only mean something for the instruction in EX/MEM while idle and unstalled.
  assign sample_c = (state_q == IDLE) && !stall;
  assign taken_c  = branch & zero;

  // Redirect / squash sequencing.
  always_comb begin
    state_d     = state_q;
    sq_cnt_d    = sq_cnt_q;
    pc_src_d    = pc_src_q;
    flush_d     = flush_q;
    busy_d      = busy_q;
    pc_target_d = pc_target_q;

    case (state_q)
      IDLE: begin
        if (sample_c && taken_c) begin
          pc_target_d = branch_target;
          pc_src_d    = 1'b1;
          flush_d     = 1'b1;
          busy_d      = 1'b1;
          sq_cnt_d    = SQ_INIT;
          state_d     = REDIRECT;
        end
      end

      REDIRECT: begin
        // pc_src must survive a stall until the PC register can actually load.
        if (!stall) begin
          pc_src_d = 1'b0;
          if (sq_cnt_q == '0) begin
            flush_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            sq_cnt_d = sq_cnt_q - SQ_W'(1);
            state_d  = SQUASH;
          end
        end
      end

      SQUASH: begin
        if (!stall) begin
          if (sq_cnt_q == '0) begin
            flush_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            sq_cnt_d = sq_cnt_q - SQ_W'(1);
          end
        end
      end

      default: begin
        state_d  = IDLE;
        pc_src_d = 1'b0;
        flush_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Saturating statistics; clear has priority over a same-cycle increment.
  always_comb begin
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (clear_stats) begin
      branch_count_d = '0;
      taken_count_d  = '0;
    end else if (sample_c && branch) begin
      if (branch_count_q != CNT_MAX) begin
        branch_count_d = branch_count_q + CNT_W'(1);
      end
      if (zero && (taken_count_q != CNT_MAX)) begin
        taken_count_d = taken_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sq_cnt_q       <= '0;
      pc_src_q       <= 1'b0;
      flush_q        <= 1'b0;
      busy_q         <= 1'b0;
      pc_target_q    <= '0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      sq_cnt_q       <= sq_cnt_d;
      pc_src_q       <= pc_src_d;
      flush_q        <= flush_d;
      busy_q         <= busy_d;
      pc_target_q    <= pc_target_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign pc_src       = pc_src_q;
  assign pc_target    = pc_target_q;
  assign flush        = flush_q;
  assign busy         = busy_q;
  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a FLUSH_DEPTH=3 instance plus a
// FLUSH_DEPTH=1 instance sharing the inputs, both with 4-bit counters.
module tb_branch_redirect_ctrl;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             branch;
  logic             zero;
  logic [PC_W-1:0]  branch_target;
  logic             stall;
  logic             clear_stats;

  logic             pc_src, flush, busy;
  logic [PC_W-1:0]  pc_target;
  logic [CNT_W-1:0] branch_count, taken_count;

  logic             pc_src1, flush1, busy1;
  logic [PC_W-1:0]  pc_target1;
  logic [CNT_W-1:0] branch_count1, taken_count1;

  int total;
  int bad;

  branch_redirect_ctrl #(.PC_W(PC_W), .FLUSH_DEPTH(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .zero(zero),
    .branch_target(branch_target), .stall(stall), .clear_stats(clear_stats),
    .pc_src(pc_src), .pc_target(pc_target), .flush(flush), .busy(busy),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  branch_redirect_ctrl #(.PC_W(PC_W), .FLUSH_DEPTH(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .branch(branch), .zero(zero),
    .branch_target(branch_target), .stall(stall), .clear_stats(clear_stats),
    .pc_src(pc_src1), .pc_target(pc_target1), .flush(flush1), .busy(busy1),
    .branch_count(branch_count1), .taken_count(taken_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic e_pc_src, input logic e_flush,
                         input logic e_busy);
    chk({tag, ".pc_src"}, 32'(pc_src), 32'(e_pc_src));
    chk({tag, ".flush"},  32'(flush),  32'(e_flush));
    chk({tag, ".busy"},   32'(busy),   32'(e_busy));
  endtask

  task automatic chk_cnt(input string tag, input int e_br, input int e_tk);
    chk({tag, ".branch_count"}, 32'(branch_count), 32'(e_br));
    chk({tag, ".taken_count"},  32'(taken_count),  32'(e_tk));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    branch_target = '0;
    stall = 1'b0;
    clear_stats = 1'b0;

    // Reset state
    #12;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.pc_target", pc_target, 32'h0);
    chk_cnt("rst", 0, 0);
    chk("rst.dut1.busy", 32'(busy1), 32'h0);
    rst_n = 1'b1;
    tick();
    chk_ctl("idle", 1'b0, 1'b0, 1'b0);

    // T2: taken branch, flush exactly 3 cycles, pc_src 1 cycle
    branch = 1'b1; zero = 1'b1; branch_target = 32'h0000_0040;
    tick();
    chk_ctl("t2.e0", 1'b1, 1'b1, 1'b1);
    chk("t2.pc_target", pc_target, 32'h40);
    chk_cnt("t2.e0", 1, 1);
    chk("t2.dut1.flush", 32'(flush1), 32'h1);
    branch = 1'b0; zero = 1'b0; branch_target = 32'h0000_0099;
    tick();
    chk_ctl("t2.c2", 1'b0, 1'b1, 1'b1);
    chk("t2.dut1.flush_end", 32'(flush1), 32'h0);
    chk("t2.dut1.busy_end", 32'(busy1), 32'h0);
    tick();
    chk_ctl("t2.c3", 1'b0, 1'b1, 1'b1);
    tick();
    chk_ctl("t2.c4", 1'b0, 1'b0, 1'b0);
    chk("t2.pc_target_hold", pc_target, 32'h40);
    chk_cnt("t2.end", 1, 1);

    // T3: not-taken, and zero without branch
    clear_stats = 1'b1;
    tick();
    chk_cnt("t3.clear", 0, 0);
    clear_stats = 1'b0;
    branch = 1'b1; zero = 1'b0;
    tick();
    chk_ctl("t3.nt", 1'b0, 1'b0, 1'b0);
    chk_cnt("t3.nt", 1, 0);
    branch = 1'b0; zero = 1'b1;
    tick();
    chk_ctl("t3.zonly", 1'b0, 1'b0, 1'b0);
    chk_cnt("t3.zonly", 1, 0);
    zero = 1'b0;

    // T4: stalls in REDIRECT and SQUASH, stalled taken branch in IDLE
    branch = 1'b1; zero = 1'b1; branch_target = 32'h0000_0100;
    tick();
    chk_ctl("t4.e0", 1'b1, 1'b1, 1'b1);
    chk("t4.pc_target", pc_target, 32'h100);
    branch = 1'b0; zero = 1'b0; stall = 1'b1;
    tick();
    chk_ctl("t4.rs1", 1'b1, 1'b1, 1'b1);
    tick();
    chk_ctl("t4.rs2", 1'b1, 1'b1, 1'b1);
    stall = 1'b0;
    tick();
    chk_ctl("t4.sq1", 1'b0, 1'b1, 1'b1);
    stall = 1'b1;
    tick();
    chk_ctl("t4.sqs", 1'b0, 1'b1, 1'b1);
    stall = 1'b0;
    tick();
    chk_ctl("t4.sq0", 1'b0, 1'b1, 1'b1);
    tick();
    chk_ctl("t4.done", 1'b0, 1'b0, 1'b0);
    chk_cnt("t4.done", 2, 1);
    branch = 1'b1; zero = 1'b1; stall = 1'b1;
    tick();
    chk_ctl("t4.idle_stall", 1'b0, 1'b0, 1'b0);
    chk_cnt("t4.idle_stall", 2, 1);
    branch = 1'b0; zero = 1'b0; stall = 1'b0;
    tick();

    // T5: taken branch every cycle -> redirect every 4 cycles
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    branch = 1'b1; zero = 1'b1; branch_target = 32'h0000_0200;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("t5.pc_src[%0d]", k), 32'(pc_src), 32'((k % 4) == 1));
      chk($sformatf("t5.flush[%0d]", k),  32'(flush),  32'((k % 4) != 0));
    end
    chk_cnt("t5.end", 3, 3);

    // T6: saturation at 15, then clear coincident with a taken branch
    clear_stats = 1'b1;
    branch = 1'b0; zero = 1'b0;
    tick();
    clear_stats = 1'b0;
    branch = 1'b1; zero = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 56) chk_cnt("t6.k56", 14, 14);
    end
    chk_cnt("t6.sat", 15, 15);
    zero = 1'b0;
    tick();
    chk_cnt("t6.sat_nt", 15, 15);
    zero = 1'b1; clear_stats = 1'b1; branch_target = 32'h0000_0300;
    tick();
    chk_cnt("t6.clear_win", 0, 0);
    chk("t6.redirect_kept", 32'(pc_src), 32'h1);
    chk("t6.target", pc_target, 32'h300);
    clear_stats = 1'b0; branch = 1'b0; zero = 1'b0;

    // T1: async reset mid-SQUASH, then a fresh redirect
    tick();
    tick();
    chk_ctl("t1.in_squash", 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ctl("t1.async", 1'b0, 1'b0, 1'b0);
    chk("t1.pc_target", pc_target, 32'h0);
    chk_cnt("t1.async", 0, 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk_ctl("t1.idle", 1'b0, 1'b0, 1'b0);
    branch = 1'b1; zero = 1'b1; branch_target = 32'h0000_0044;
    tick();
    chk_ctl("t1.new", 1'b1, 1'b1, 1'b1);
    chk("t1.new_target", pc_target, 32'h44);
    chk_cnt("t1.new", 1, 1);
    branch = 1'b0; zero = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
